probe_rle_packer: RTL
=====================

PROBE_RLE_PACKER -- requirements
Module: probe_rle_packer

Interface
REQ-001 Parameter DEPTH_LOG2, default 4: token buffer holds 2**DEPTH_LOG2 tokens.
REQ-002 clk  input  1  single clock, all state on rising edge; same domain as FX2 FIFO interface.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 sample  input  8  synchronized probe byte, one per clock.
REQ-005 enable  input  1  capture enable; samples counted only while high.
REQ-006 fifo_full  input  1  active-high downstream FIFO full flag.
REQ-007 fifo_data  output  8  byte presented to downstream FIFO.
REQ-008 fifo_wr  output  1  write strobe; byte accepted on any edge where fifo_wr is high.
REQ-009 overflow  output  1  sticky flag: at least one token dropped.
REQ-010 busy  output  1  high while an open run, buffered token or serializer activity exists.

Function
REQ-011 Token SHALL be 2 bytes: value byte (sample), then count byte (run length minus 1, 0..255).
REQ-012 Run tracker SHALL hold cur_value[7:0], run_count[7:0], run_valid.
REQ-013 enable high, run_valid low: cur_value<=sample, run_count<=0, run_valid<=1, nothing pushed.
REQ-014 enable high, run_valid high, sample==cur_value, run_count!=255: run_count<=run_count+1.
REQ-015 enable high, run_valid high, sample!=cur_value or run_count==255: push {cur_value,run_count}; cur_value<=sample, run_count<=0.
REQ-016 enable low, run_valid high: push {cur_value,run_count}; run_valid<=0.
REQ-017 enable low, run_valid low: no action; runs never span an enable-low gap.
REQ-018 Push writes the buffer on the same edge that closes the run.
REQ-019 Push SHALL succeed when buffer not full or a pop occurs on the same edge; otherwise token dropped and overflow<=1.
REQ-020 overflow SHALL clear only on reset.
REQ-021 Buffer SHALL be a circular FIFO; read/write pointers wrap modulo 2**DEPTH_LOG2; occupancy counter DEPTH_LOG2+1 bits.
REQ-022 Serializer states: IDLE, SEND_VALUE, SEND_COUNT.
REQ-023 IDLE -> SEND_VALUE when buffer non-empty; stays IDLE otherwise.
REQ-024 SEND_VALUE: fifo_data=head value; on edge with fifo_wr high -> SEND_COUNT.
REQ-025 SEND_COUNT: fifo_data=head count; on edge with fifo_wr high pop head; -> SEND_VALUE if post-pop occupancy non-zero, else IDLE.
REQ-026 fifo_wr SHALL equal (state!=IDLE) AND NOT fifo_full, combinationally.
REQ-027 fifo_full high SHALL hold state and fifo_data unchanged; no byte skipped or duplicated.
REQ-028 Latency: run closed at edge E; fifo_wr may first rise in cycle after edge E+1 (two edges from close to value-byte strobe).
REQ-029 Back-to-back tokens SHALL stream with no idle cycle between count byte and next value byte.
REQ-030 busy = run_valid OR occupancy!=0 OR state!=IDLE.
REQ-031 Sustained output rate 1 token per 2 clocks; excess absorbed by buffer, then REQ-019 applies.

Reset
REQ-032 reset_n low SHALL immediately force: state IDLE, pointers and occupancy 0, run_valid 0, run_count 0, cur_value 0, overflow 0, fifo_data 0x00, fifo_wr 0, busy 0.
REQ-033 Reset mid-token SHALL discard partially sent token; no remaining byte emitted after release.
REQ-034 First edge after reset_n rises SHALL behave per REQ-013..017.

Verification
REQ-035 sample=0x3C, enable high 300 cycles, then low, fifo_full=0 -> bytes 3C,FF,3C,2B; overflow=0; busy falls after last byte.
REQ-036 enable high for one cycle with sample=0xA5 -> bytes A5,00 exactly.
REQ-037 sample alternates 0x01/0x02 each cycle for 40 enabled cycles, fifo_full=1 throughout; then enable low, fifo_full=0 -> overflow=1; exactly 16 tokens out: 01,00,02,00,... (first 16 closed runs, in order).
REQ-038 fifo_full raised for 5 cycles after value byte 0x7E written -> fifo_wr low 5 cycles, fifo_data holds count byte, then count written once.
REQ-039 sample=0x55 constant, enable high 10, low 3, high 10, low -> 55,09,55,09.
REQ-040 reset_n pulsed low while in SEND_COUNT with 3 tokens buffered -> fifo_wr 0 same cycle, no further bytes, busy=0, overflow=0.

Source files
------------

// File: rtl/probe_rle_packer.sv
// Run-length packer for logic-analyzer probe bytes.
// Collapses runs of identical samples into 2-byte tokens (value, length-1),
// buffers them in a small circular FIFO and serializes them onto an
// 8-bit downstream FIFO interface with a full-flag handshake.
module probe_rle_packer #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] sample,
   input  logic       enable,
   input  logic       fifo_full,
   output logic [7:0] fifo_data,
   output logic       fifo_wr,
   output logic       overflow,
   output logic       busy
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_OCC = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, SEND_VALUE, SEND_COUNT} state_t;

   state_t                state, state_next;
   logic [7:0]            cur_value;
   logic [7:0]            run_count;
   logic                  run_valid;
   logic [15:0]           token_mem [DEPTH];
   logic [15:0]           head;
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]   occupancy, occupancy_next;
   logic                  push, push_ok, pop;

   // A run closes on a new value, a saturated count, or capture disable.
   assign push    = run_valid && (!enable || (sample != cur_value) || (run_count == 8'hFF));
   assign fifo_wr = (state != IDLE) && !fifo_full;
   assign pop     = (state == SEND_COUNT) && fifo_wr;
   // A pop on the same edge frees a slot, so a full buffer can still accept.
   assign push_ok = push && ((occupancy != FULL_OCC) || pop);
   assign head    = token_mem[rd_ptr];
   assign busy    = run_valid || (occupancy != '0) || (state != IDLE);

   // Occupancy after this edge; the serializer uses it to decide whether to stream on.
   always_comb begin
      occupancy_next = occupancy;
      case ({push_ok, pop})
         2'b10:   occupancy_next = occupancy + 1'b1;
         2'b01:   occupancy_next = occupancy - 1'b1;
         default: occupancy_next = occupancy;
      endcase
   end

   // Run tracker: open, extend or close the current run.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_value <= 8'h00;
         run_count <= 8'h00;
         run_valid <= 1'b0;
      end else if (enable) begin
         if (!run_valid || push) begin
            cur_value <= sample;
            run_count <= 8'h00;
            run_valid <= 1'b1;
         end else begin
            run_count <= run_count + 8'd1;
         end
      end else begin
         run_valid <= 1'b0;
      end
   end

   // Token storage is data only, so it carries no reset.
   always_ff @(posedge clk) begin
      if (push_ok) token_mem[wr_ptr] <= {cur_value, run_count};
   end

   // Buffer pointers, occupancy and sticky drop flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
         overflow  <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         occupancy <= occupancy_next;
         if (push && !push_ok) overflow <= 1'b1;
      end
   end

   // Serializer state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Serializer next state and output byte; a stalled write leaves both unchanged.
   always_comb begin
      state_next = state;
      fifo_data  = 8'h00;
      case (state)
         IDLE: begin
            if (occupancy != '0) state_next = SEND_VALUE;
         end
         SEND_VALUE: begin
            fifo_data = head[15:8];
            if (fifo_wr) state_next = SEND_COUNT;
         end
         SEND_COUNT: begin
            fifo_data = head[7:0];
            if (fifo_wr) state_next = (occupancy_next != '0) ? SEND_VALUE : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
